// File: rtl/alu_arbiter_seq.sv
// ---------------------------------------------------------------------------
// alu_arbiter_seq
//
// Sequencer and two-port round-robin arbiter in front of the shared
// combinational ALU. One requester at a time is accepted, its opcode and
// operands are latched and held on the ALU inputs for a per-opcode settle
// window, the 64-bit ALU result is captured, and the result is handed back
// to the granted requester over a response handshake.
//
// Parameters:
//   ALU_WAIT  settle cycles for every opcode except multiply (>= 1)
//   MUL_WAIT  settle cycles for opcode 10, multiply (>= 1)
//
// Ports:
//   clock                     system clock, rising edge
//   clear                     asynchronous active-high reset
//   req0_valid / req1_valid   requester N has an operation pending
//   req0_ready / req1_ready   requester N is accepted this cycle (combinational)
//   req0_op    / req1_op      5-bit opcode
//   req0_a, req0_b / req1_a, req1_b   32-bit operands
//   rsp0_valid / rsp1_valid   result available for requester N
//   rsp0_ready / rsp1_ready   requester N takes the result
//   rsp_hi, rsp_lo            result bits 63:32 / 31:0 (shared)
//   alu_a, alu_b, alu_op      ALU input drives
//   alu_c                     ALU 64-bit result
//   busy                      sequencer is not idle
//   grant_id                  index of the current or most recent grant
// ---------------------------------------------------------------------------
module alu_arbiter_seq #(
  parameter int ALU_WAIT = 1,
  parameter int MUL_WAIT = 3
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [63:0] alu_c,
  output logic        busy,
  output logic        grant_id
);

  localparam int MAX_WAIT = (MUL_WAIT > ALU_WAIT) ? MUL_WAIT : ALU_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_WAIT);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [4:0]       OP_MUL  = 5'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Settle window for an opcode; only multiply takes the long path.
  function automatic logic [CNT_W-1:0] wait_for_op(input logic [4:0] op);
    if (op == OP_MUL) begin
      return MUL_CNT;
    end else begin
      return ALU_CNT;
    end
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              grant_q, grant_d;
  logic [4:0]        op_q, op_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [63:0]       res_q, res_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic              busy_q, busy_d;

  logic              sel_valid_s;
  logic              sel_id_s;
  logic [4:0]        sel_op_s;
  logic [31:0]       sel_a_s;
  logic [31:0]       sel_b_s;
  logic              rsp_take_s;

  // Requester selection: a lone requester wins; on a tie the one that was
  // not served last wins.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_id_s    = 1'b0;
    if (req0_valid && req1_valid) begin
      sel_valid_s = 1'b1;
      sel_id_s    = ~last_q;
    end else if (req0_valid) begin
      sel_valid_s = 1'b1;
      sel_id_s    = 1'b0;
    end else if (req1_valid) begin
      sel_valid_s = 1'b1;
      sel_id_s    = 1'b1;
    end else begin
      sel_valid_s = 1'b0;
      sel_id_s    = 1'b0;
    end
  end

  // Operand mux for the selected requester.
  always_comb begin
    sel_op_s = req0_op;
    sel_a_s  = req0_a;
    sel_b_s  = req0_b;
    if (sel_id_s) begin
      sel_op_s = req1_op;
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
    end else begin
      sel_op_s = req0_op;
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
    end
  end

  // Request ready is only offered while idle, and only to the selected port.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == ST_IDLE) begin
      req0_ready = sel_valid_s & ~sel_id_s;
      req1_ready = sel_valid_s &  sel_id_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  // Only the granted port's response ready matters.
  always_comb begin
    rsp_take_s = 1'b0;
    if (grant_q) begin
      rsp_take_s = rsp1_ready;
    end else begin
      rsp_take_s = rsp0_ready;
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid_s) begin
          op_d    = sel_op_s;
          a_d     = sel_a_s;
          b_d     = sel_b_s;
          grant_d = sel_id_s;
          cnt_d   = wait_for_op(sel_op_s);
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          res_d   = alu_c;
          state_d = ST_RESP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_RESP: begin
        if (rsp_take_s) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next-state values so they change
  // together with the state register.
  always_comb begin
    busy_d       = (state_d != ST_IDLE);
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    if (state_d == ST_RESP) begin
      rsp0_valid_d = ~grant_d;
      rsp1_valid_d =  grant_d;
    end else begin
      rsp0_valid_d = 1'b0;
      rsp1_valid_d = 1'b0;
    end
  end

  // State and datapath registers; last resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_q       <= 1'b1;
      grant_q      <= 1'b0;
      op_q         <= 5'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      res_q        <= 64'd0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      busy_q       <= busy_d;
    end
  end

  // Operand registers hold after the operation, so the ALU inputs stay put in idle.
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_hi     = res_q[63:32];
  assign rsp_lo     = res_q[31:0];
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// ---------------------------------------------------------------------------
// Self-checking bench for alu_arbiter_seq: a behavioural ALU drives alu_c,
// directed vectors and multi-cycle sequences cover the listed scenarios, and
// a randomized phase is checked against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_alu_arbiter_seq;

  localparam int ALU_W = 1;
  localparam int MUL_W = 3;

  logic        clock;
  logic        clear;
  logic        req0_valid, req0_ready;
  logic [4:0]  req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [4:0]  req1_op;
  logic [31:0] req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready;
  logic        rsp1_valid, rsp1_ready;
  logic [31:0] rsp_hi, rsp_lo;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_op;
  logic [63:0] alu_c;
  logic        busy;
  logic        grant_id;

  int checks;
  int failures;

  alu_arbiter_seq #(.ALU_WAIT(ALU_W), .MUL_WAIT(MUL_W)) dut (
    .clock(clock), .clear(clear),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .busy(busy), .grant_id(grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU: non-multiply results sign-extended, multiply unsigned 32x32.
  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    logic [5:0]  sh;
    logic [5:0]  inv;
    sh  = {1'b0, b[4:0]};
    inv = 6'd32 - sh;
    case (op)
      5'd0:    r = a | b;
      5'd1:    r = a & b;
      5'd2:    r = a + b;
      5'd3:    r = a - b;
      5'd4:    r = 32'd0 - a;
      5'd5:    r = a >> sh;
      5'd6:    r = a << sh;
      5'd7:    r = (a >> sh) | (a << inv);
      5'd8:    r = (a << sh) | (a >> inv);
      5'd9:    r = $signed(a) >>> sh;
      default: r = a & b;
    endcase
    if (op == 5'd10) return {32'd0, a} * {32'd0, b};
    return {{32{r[31]}}, r};
  endfunction

  always_comb alu_c = alu_fn(alu_op, alu_a, alu_b);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 1) ? req1_ready : req0_ready;
  endfunction

  function automatic logic rspv(input int id);
    return (id == 1) ? rsp1_valid : rsp0_valid;
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input int id, input logic v, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    if (id == 1) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // One full operation on port id with both response readies high. Entered
  // and left just after a rising edge.
  task automatic do_op(input string name, input int id, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int k;
    int w;
    w = (op == 5'd10) ? MUL_W : ALU_W;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    drive_req(id, 1'b1, op, a, b);
    k = 0;
    @(negedge clock);
    while (!rdy(id) && k < 20) begin
      next_cycle(); @(negedge clock); k++;
    end
    chk({name, "_ready"}, 64'(rdy(id)), 64'd1);
    next_cycle();
    // Scramble inputs: only the latched copies may be used from here on.
    drive_req(id, 1'b0, 5'($urandom), $urandom, $urandom);
    k = 1;
    @(negedge clock);
    while (!rspv(id) && k < 20) begin
      chk({name, "_alu_op"}, 64'(alu_op), 64'(op));
      chk({name, "_alu_a"}, 64'(alu_a), 64'(a));
      chk({name, "_other_rsp"}, 64'((id == 1) ? rsp0_valid : rsp1_valid), 64'd0);
      next_cycle(); @(negedge clock); k++;
    end
    chk({name, "_latency"}, 64'(k), 64'(w + 1));
    chk({name, "_result"}, {rsp_hi, rsp_lo}, exp);
    chk({name, "_grant"}, 64'(grant_id), 64'(id));
    chk({name, "_other_rsp"}, 64'((id == 1) ? rsp0_valid : rsp1_valid), 64'd0);
    next_cycle(); @(negedge clock);
    chk({name, "_busy_after"}, 64'(busy), 64'd0);
    chk({name, "_rsp_after"}, 64'(rspv(id)), 64'd0);
    next_cycle();
  endtask

  typedef struct {
    string       name;
    int          id;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  // Transaction-level model state for the random phase.
  int          m_owner;
  int          m_last;
  int          m_done;
  logic [63:0] m_exp;
  logic [4:0]  m_op;
  logic [31:0] m_a;
  int          m_grants;

  initial begin
    int          k;
    int          q[$];
    logic        e_sv, e_sid;
    logic [4:0]  e_op;

    checks = 0; failures = 0;
    clear = 1'b1;
    req0_valid = 1'b0; req0_op = 5'd0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_op = 5'd0; req1_a = 32'd0; req1_b = 32'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    vecs[0] = '{"add",     0, 5'd2,  32'd5,          32'd7,          64'h0000_0000_0000_000C};
    vecs[1] = '{"sub_neg", 1, 5'd3,  32'd3,          32'd5,          64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2] = '{"mul",     0, 5'd10, 32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};
    vecs[3] = '{"and",     1, 5'd1,  32'hF0F0_1234,  32'h0FF0_FFFF,  64'h0000_0000_00F0_1234};
    vecs[4] = '{"or_sx",   0, 5'd0,  32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0001};
    vecs[5] = '{"neg",     1, 5'd4,  32'd1,          32'd0,          64'hFFFF_FFFF_FFFF_FFFF};
    vecs[6] = '{"shl",     0, 5'd6,  32'd1,          32'd4,          64'h0000_0000_0000_0010};
    vecs[7] = '{"mul_big", 1, 5'd10, 32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE};

    repeat (2) next_cycle();
    clear = 1'b0;
    @(negedge clock);
    chk("reset_status", 64'({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, grant_id}), 64'd0);
    chk("reset_alu", {alu_a, alu_b}, 64'd0);
    chk("reset_alu_op", 64'(alu_op), 64'd0);
    chk("reset_rsp", {rsp_hi, rsp_lo}, 64'd0);
    next_cycle();

    // Reset during the second EXEC cycle of a multiply aborts it.
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    drive_req(0, 1'b1, 5'd10, 32'h0001_0000, 32'd3);
    k = 0;
    @(negedge clock);
    while (!req0_ready && k < 20) begin next_cycle(); @(negedge clock); k++; end
    chk("abort_ready", 64'(req0_ready), 64'd1);
    next_cycle();
    drive_req(0, 1'b0, 5'd0, 32'd0, 32'd0);
    next_cycle();
    clear = 1'b1;
    #1;
    chk("abort_status", 64'({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, grant_id}), 64'd0);
    chk("abort_alu", {alu_a, alu_b}, 64'd0);
    chk("abort_alu_op", 64'(alu_op), 64'd0);
    chk("abort_rsp", {rsp_hi, rsp_lo}, 64'd0);
    next_cycle();
    clear = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("abort_no_rsp", 64'({rsp0_valid, busy}), 64'd0);
      next_cycle();
    end
    do_op("abort_next", 1, 5'd2, 32'd10, 32'd20, 64'd30);

    // Directed vector table.
    foreach (vecs[i]) do_op(vecs[i].name, vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Contention: last grant went to port 1, so grants go 0,1,0,1.
    drive_req(0, 1'b1, 5'd2, 32'd1, 32'd2);
    drive_req(1, 1'b1, 5'd2, 32'd3, 32'd4);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk("cont_excl", 64'(req0_ready & req1_ready), 64'd0);
      if (req0_ready) q.push_back(0);
      if (req1_ready) q.push_back(1);
      next_cycle();
    end
    drive_req(0, 1'b0, 5'd0, 32'd0, 32'd0);
    drive_req(1, 1'b0, 5'd0, 32'd0, 32'd0);
    chk("cont_grants", 64'(q.size()), 64'd4);
    for (int i = 0; i < q.size() && i < 4; i++) chk("cont_order", 64'(q[i]), 64'(i % 2));
    repeat (2) next_cycle();

    // Backpressure on port 1 while port 0 waits.
    rsp1_ready = 1'b0;
    drive_req(1, 1'b1, 5'd2, 32'd100, 32'd23);
    k = 0;
    @(negedge clock);
    while (!req1_ready && k < 20) begin next_cycle(); @(negedge clock); k++; end
    chk("bp_ready1", 64'(req1_ready), 64'd1);
    next_cycle();
    drive_req(1, 1'b0, 5'd0, 32'd0, 32'd0);
    drive_req(0, 1'b1, 5'd2, 32'd1, 32'd1);
    k = 0;
    @(negedge clock);
    while (!rsp1_valid && k < 20) begin
      chk("bp_wait_ready0", 64'(req0_ready), 64'd0);
      next_cycle(); @(negedge clock); k++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(rsp1_valid), 64'd1);
      chk("bp_data", {rsp_hi, rsp_lo}, 64'd123);
      chk("bp_ready0", 64'(req0_ready), 64'd0);
      chk("bp_grant", 64'(grant_id), 64'd1);
      next_cycle(); @(negedge clock);
    end
    next_cycle();
    rsp1_ready = 1'b1;
    @(negedge clock);
    chk("bp_accept_valid", 64'(rsp1_valid), 64'd1);
    chk("bp_accept_ready0", 64'(req0_ready), 64'd0);
    next_cycle(); @(negedge clock);
    chk("bp_idle_ready0", 64'(req0_ready), 64'd1);
    chk("bp_idle_rsp1", 64'(rsp1_valid), 64'd0);
    next_cycle();
    drive_req(0, 1'b0, 5'd0, 32'd0, 32'd0);
    k = 0;
    @(negedge clock);
    while (!rsp0_valid && k < 20) begin next_cycle(); @(negedge clock); k++; end
    chk("bp_req0_result", {rsp_hi, rsp_lo}, 64'd2);
    next_cycle();

    // Randomized traffic checked against a transaction-level model.
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    m_owner = -1; m_last = 1; m_done = 0; m_grants = 0;
    m_exp = 64'd0; m_op = 5'd0; m_a = 32'd0;
    for (int n = 0; n < 3000; n++) begin
      drive_req(0, ($urandom_range(0, 9) < 6), ($urandom_range(0, 3) == 0) ? 5'd10 : 5'($urandom),
                $urandom, $urandom);
      drive_req(1, ($urandom_range(0, 9) < 6), ($urandom_range(0, 3) == 0) ? 5'd10 : 5'($urandom),
                $urandom, $urandom);
      rsp0_ready = 1'($urandom);
      rsp1_ready = 1'($urandom);
      @(negedge clock);
      if (m_owner < 0) begin
        e_sv  = req0_valid | req1_valid;
        e_sid = (req0_valid && req1_valid) ? (m_last == 0) : req1_valid;
        chk("rnd_idle_busy", 64'(busy), 64'd0);
        chk("rnd_idle_rsp", 64'({rsp1_valid, rsp0_valid}), 64'd0);
        chk("rnd_ready", 64'({req1_ready, req0_ready}),
            e_sv ? (e_sid ? 64'd2 : 64'd1) : 64'd0);
        if (e_sv) begin
          e_op     = e_sid ? req1_op : req0_op;
          m_owner  = e_sid ? 1 : 0;
          m_op     = e_op;
          m_a      = e_sid ? req1_a : req0_a;
          m_exp    = e_sid ? alu_fn(req1_op, req1_a, req1_b) : alu_fn(req0_op, req0_a, req0_b);
          m_done   = n + ((e_op == 5'd10) ? MUL_W : ALU_W) + 1;
          m_grants++;
        end
      end else if (n < m_done) begin
        chk("rnd_exec_status", 64'({busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid}), 64'h10);
        chk("rnd_exec_alu_op", 64'(alu_op), 64'(m_op));
        chk("rnd_exec_alu_a", 64'(alu_a), 64'(m_a));
        chk("rnd_exec_grant", 64'(grant_id), 64'(m_owner));
      end else begin
        chk("rnd_resp_status", 64'({busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid}),
            (m_owner == 1) ? 64'h12 : 64'h11);
        chk("rnd_resp_data", {rsp_hi, rsp_lo}, m_exp);
        chk("rnd_resp_grant", 64'(grant_id), 64'(m_owner));
        if ((m_owner == 1) ? rsp1_ready : rsp0_ready) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
      next_cycle();
    end
    chk("rnd_some_grants", 64'(m_grants > 100), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter_seq.md
# alu_arbiter_seq

Sequencer and two-port arbiter for the shared combinational ALU. Accepts operation requests (opcode plus two 32-bit operands) from two requesters over valid/ready handshakes and grants one at a time, round-robin. It holds the ALU inputs stable for a per-opcode settle window, then captures the 64-bit ALU result into a result register. The result is returned to the granted requester over a response handshake. The block sits between the datapath control units and the ALU, so the ALU itself never sees conflicting drivers.

## Interface
Parameters:
- ALU_WAIT, default 1: cycles in EXEC for opcodes other than 10 (minimum 1).
- MUL_WAIT, default 3: cycles in EXEC for opcode 10 (multiply, long path; minimum 1).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  reset, asynchronous, active-high.
- req0_valid / req1_valid  in  1  requester N has an operation pending.
- req0_ready / req1_ready  out  1  arbiter accepts requester N this cycle.
- req0_op / req1_op  in  5  ALU opcode.
- req0_a, req0_b / req1_a, req1_b  in  32 each  operands.
- rsp0_valid / rsp1_valid  out  1  result available for requester N.
- rsp0_ready / rsp1_ready  in  1  requester N takes the result.
- rsp_hi  out  32  result bits 63:32 (shared by both requesters).
- rsp_lo  out  32  result bits 31:0 (shared by both requesters).
- alu_a, alu_b  out  32  ALU operand drives.
- alu_op  out  5  ALU opcode drive.
- alu_c  in  64  ALU result.
- busy  out  1  state is not IDLE.
- grant_id  out  1  index of the current or most recent grant.

## Operation
- Opcodes: 0 or, 1 and, 2 add, 3 sub, 4 neg, 5 shr, 6 shl, 7 ror, 8 rol, 9 shra, 10 mul.
  - Opcodes 11–31 are forwarded unchanged and use ALU_WAIT; the result is whatever the ALU returns (sign-extended AND).
- Results:
  - Non-multiply results arrive from the ALU already sign-extended to 64 bits.
  - The arbiter never alters result bits; it only registers them.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Selection: if exactly one reqN_valid is high, select N. If both are high, select the requester that is not `last`.
  - reqN_ready is combinational: high only in IDLE, and only for the selected N.
  - On valid&ready: latch op, a and b into the operand registers; grant_id <= N; cnt <= (op==10 ? MUL_WAIT : ALU_WAIT); go to EXEC.
- EXEC:
  - alu_a, alu_b and alu_op come from the operand registers and are stable for the whole state.
  - If cnt==1: result register <= alu_c, go to RESP. Otherwise cnt <= cnt-1.
- RESP:
  - rsp[grant_id]_valid=1; rsp_hi and rsp_lo come from the result register.
  - On rsp[grant_id]_ready: last <= grant_id, go to IDLE.
  - rsp_ready of the non-granted port is ignored.
- The operand registers keep their last values after the operation; alu_* outputs therefore hold their values in IDLE.
- A requester may drop valid before it is granted; nothing is recorded.
- A requester must hold op, a and b only until its handshake; the arbiter uses only the latched copies after that.

## Timing
- Reset (clear high, asynchronous):
  - State IDLE; cnt 0; last 1, so requester 0 wins the first tie.
  - grant_id 0; operand and result registers 0.
  - All outputs 0: alu_*, rsp_hi, rsp_lo, rspN_valid, reqN_ready, busy.
- Reset mid-EXEC or mid-RESP aborts the operation; no response is ever issued for it.
- Latency: handshake in cycle T; EXEC occupies cycles T+1 .. T+W; rsp valid from cycle T+W+1. W is ALU_WAIT or MUL_WAIT.
- Minimum spacing between grants is W+2 cycles, because every handshake occurs in IDLE.
- Response backpressure:
  - rsp_valid, rsp_hi, rsp_lo and grant_id hold indefinitely until ready.
  - No new request is granted while a response is pending.
- A request arriving during EXEC or RESP waits, with ready low, until the next IDLE.

## Test plan
- Reset abort: clear asserted in the 2nd EXEC cycle of a multiply → all outputs 0 on the same cycle; no rsp0_valid afterwards; next req1 add is granted normally.
- Add: req0 op=2, a=5, b=7, rsp0_ready held high → rsp0_valid exactly at handshake+ALU_WAIT+1; rsp_hi=0x00000000, rsp_lo=0x0000000C; busy low the cycle after.
- Sub negative: req1 op=3, a=3, b=5 → rsp_hi=0xFFFFFFFF, rsp_lo=0xFFFFFFFE; rsp0_valid stays 0 throughout.
- Multiply: req0 op=10, a=0x00010000, b=0x00010000 → alu_op=10 held for MUL_WAIT cycles; rsp_hi=0x00000001, rsp_lo=0x00000000.
- Contention: both requesters valid continuously with add operations → grants alternate 0,1,0,1 starting with 0; each grant gets exactly one ready pulse.
- Backpressure: rsp1_ready low for 5 cycles while req0_valid is high → rsp1_valid and data stable all 5 cycles; req0_ready stays 0; req0 is granted in the IDLE cycle after rsp1 is accepted.
